// File: rtl/regfile_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : regfile_pkg                                               |
// | Purpose  : Shared helpers for the scoreboarded register file: PC     |
// |            index, address width and the busy-vector container type.  |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
package regfile_pkg;

  // Busy vectors are carried in a fixed-width container; only the low
  // NREGS-1 bits of it are ever set by the scoreboard.
  localparam int MAX_NREGS = 64;
  localparam int BUSY_IW   = $clog2(MAX_NREGS);

  typedef logic [MAX_NREGS-1:0] busy_vec_t;

  // The PC always lives in the highest register index.
  function automatic int pc_index(input int nregs);
    return nregs - 1;
  endfunction

  // Register address width; never narrower than one bit.
  function automatic int addr_width(input int nregs);
    return (nregs > 1) ? $clog2(nregs) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_scoreboard.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : regfile_scoreboard                                        |
// | Purpose  : Busy bits, issue acceptance, pending count and sticky     |
// |            writeback-error flag for the register file.               |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter  int NREGS = 16,
  localparam int AW    = addr_width(NREGS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic          iss_en,
  input  logic [AW-1:0] iss_addr,
  output logic          wr_ok,
  output logic          iss_ok,
  output busy_vec_t     busy,
  output logic [AW:0]   pend_cnt,
  output logic          wb_err
);

  localparam logic [AW-1:0] c_pc_addr = AW'(pc_index(NREGS));
  localparam logic [AW:0]   c_one     = (AW+1)'(1);

  busy_vec_t             r_busy;
  busy_vec_t             w_busy_nxt;
  logic [AW:0]           r_cnt;
  logic                  r_err;
  logic [BUSY_IW-1:0]    w_wr_idx;
  logic [BUSY_IW-1:0]    w_iss_idx;
  logic                  w_same;
  logic                  w_inc;
  logic                  w_dec;

  assign w_wr_idx  = BUSY_IW'(wr_addr);
  assign w_iss_idx = BUSY_IW'(iss_addr);

  // Writebacks to the PC index are silently dropped; nothing is accepted in reset.
  assign wr_ok  = !rst && wr_en && (wr_addr < c_pc_addr);
  assign w_same = wr_ok && (wr_addr == iss_addr);
  // A busy destination may be re-issued when its writeback lands this cycle.
  assign iss_ok = !rst && iss_en && (iss_addr < c_pc_addr) &&
                  (!r_busy[w_iss_idx] || w_same);

  // Clear on writeback first so a same-cycle issue to that register wins.
  always_comb begin
    w_busy_nxt = r_busy;
    if (wr_ok)  w_busy_nxt[w_wr_idx]  = 1'b0;
    if (iss_ok) w_busy_nxt[w_iss_idx] = 1'b1;
  end

  // An accepted issue always makes one more register busy; a writeback only
  // retires one when its target was actually busy.
  assign w_inc = iss_ok;
  assign w_dec = wr_ok && r_busy[w_wr_idx];

  // Scoreboard state: busy bits, running popcount and sticky error.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy <= '0;
      r_cnt  <= '0;
      r_err  <= 1'b0;
    end else begin
      r_busy <= w_busy_nxt;
      case ({w_inc, w_dec})
        2'b10:   r_cnt <= r_cnt + c_one;
        2'b01:   r_cnt <= r_cnt - c_one;
        default: r_cnt <= r_cnt;
      endcase
      r_err  <= r_err | (wr_ok && !r_busy[w_wr_idx]);
    end
  end

  assign busy     = r_busy;
  assign pend_cnt = r_cnt;
  assign wb_err   = r_err;

endmodule
`default_nettype wire

// File: rtl/regfile_sb.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : regfile_sb                                                |
// | Purpose  : Multi-read-port register file with PC at the top index    |
// |            and an issue/writeback scoreboard.                        |
// | Options  : REGFILE_BYPASS_EN - forward same-cycle writeback data to  |
// |            matching read ports (and report them not busy).           |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module regfile_sb
  import regfile_pkg::*;
#(
  parameter  int DATA_W = 32,
  parameter  int NREGS  = 16,
  parameter  int NRD    = 3,
  localparam int AW     = addr_width(NREGS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NRD*AW-1:0]     rd_addr,
  output logic [NRD*DATA_W-1:0] rd_data,
  output logic [NRD-1:0]        rd_busy,
  input  logic [DATA_W-1:0]     pc_wr,
  output logic [DATA_W-1:0]     pc_rd,
  input  logic                  wr_en,
  input  logic [AW-1:0]         wr_addr,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic                  iss_en,
  input  logic [AW-1:0]         iss_addr,
  output logic                  iss_ok,
  output logic [AW:0]           pend_cnt,
  output logic                  wb_err
);

  localparam logic [AW-1:0] c_pc_addr = AW'(pc_index(NREGS));

  logic [DATA_W-1:0] r_mem [NREGS];
  busy_vec_t         w_busy;
  logic              w_wr_ok;

  regfile_scoreboard #(
    .NREGS (NREGS)
  ) u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .iss_en   (iss_en),
    .iss_addr (iss_addr),
    .wr_ok    (w_wr_ok),
    .iss_ok   (iss_ok),
    .busy     (w_busy),
    .pend_cnt (pend_cnt),
    .wb_err   (wb_err)
  );

  // Storage: PC reloads every cycle, general registers on accepted writeback.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mem <= '{default: '0};
    end else begin
      r_mem[c_pc_addr] <= pc_wr;
      if (w_wr_ok) r_mem[wr_addr] <= wr_data;
    end
  end

  assign pc_rd = r_mem[c_pc_addr];

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [AW-1:0]     w_addr;
    logic [DATA_W-1:0] w_data;
    logic              w_bsy;

    assign w_addr = rd_addr[i*AW +: AW];

    // Read mux: general register, PC, or zero for out-of-range addresses.
    always_comb begin
      w_data = '0;
      w_bsy  = 1'b0;
      if (w_addr < c_pc_addr) begin
        w_data = r_mem[w_addr];
        w_bsy  = w_busy[BUSY_IW'(w_addr)];
      end else if (w_addr == c_pc_addr) begin
        w_data = r_mem[c_pc_addr];
      end
`ifdef REGFILE_BYPASS_EN
      if (w_wr_ok && (wr_addr == w_addr)) begin
        w_data = wr_data;
        w_bsy  = 1'b0;
      end
`endif
    end

    assign rd_data[i*DATA_W +: DATA_W] = w_data;
    assign rd_busy[i]                  = w_bsy;
  end

endmodule
`default_nettype wire

// File: tb/tb_regfile_sb.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_regfile_sb                                             |
// | Purpose  : Self-checking bench for regfile_sb (default 32x16, 3 RD). |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module tb_regfile_sb;

  localparam int DW  = 32;
  localparam int NR  = 16;
  localparam int NRD = 3;
  localparam int AW  = 4;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NRD*AW-1:0]     rd_addr;
  logic [NRD*DW-1:0]     rd_data;
  logic [NRD-1:0]        rd_busy;
  logic [DW-1:0]         pc_wr;
  logic [DW-1:0]         pc_rd;
  logic                  wr_en;
  logic [AW-1:0]         wr_addr;
  logic [DW-1:0]         wr_data;
  logic                  iss_en;
  logic [AW-1:0]         iss_addr;
  logic                  iss_ok;
  logic [AW:0]           pend_cnt;
  logic                  wb_err;

  int          vectors     = 0;
  int          miscompares = 0;
  logic [31:0] exp_q [$];
  logic [31:0] e;

  regfile_sb #(
    .DATA_W (DW),
    .NREGS  (NR),
    .NRD    (NRD)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_busy  (rd_busy),
    .pc_wr    (pc_wr),
    .pc_rd    (pc_rd),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .iss_en   (iss_en),
    .iss_addr (iss_addr),
    .iss_ok   (iss_ok),
    .pend_cnt (pend_cnt),
    .wb_err   (wb_err)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en  = 1'b0;
    iss_en = 1'b0;
  endtask

  task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1, input logic [AW-1:0] a2);
    rd_addr = {a2, a1, a0};
  endtask

  task automatic test_reset();
    rst = 1'b1; pc_wr = 32'h0; set_rd(0, 1, 2);
    wr_en = 1'b1; wr_addr = 4'd2; wr_data = 32'hFF;
    iss_en = 1'b1; iss_addr = 4'd2;
    exp_q.push_back(32'd0);
    #1;
    e = exp_q.pop_front(); vectors++;
    if (32'(iss_ok) !== e) begin miscompares++; $display("FAIL iss_ok_in_reset: got %h want %h", iss_ok, e); end
    cyc(); cyc();
    idle(); rst = 1'b0;
    exp_q.push_back(32'd0); exp_q.push_back(32'd0); exp_q.push_back(32'd0);
    exp_q.push_back(32'd0); exp_q.push_back(32'd0); exp_q.push_back(32'd0);
    #1;
    e = exp_q.pop_front(); vectors++;
    if (rd_data[31:0] !== e) begin miscompares++; $display("FAIL reset_rd0: got %h want %h", rd_data[31:0], e); end
    e = exp_q.pop_front(); vectors++;
    if (rd_data[63:32] !== e) begin miscompares++; $display("FAIL reset_rd1: got %h want %h", rd_data[63:32], e); end
    e = exp_q.pop_front(); vectors++;
    if (rd_data[95:64] !== e) begin miscompares++; $display("FAIL reset_rd2: got %h want %h", rd_data[95:64], e); end
    e = exp_q.pop_front(); vectors++;
    if (32'(rd_busy) !== e) begin miscompares++; $display("FAIL reset_busy: got %h want %h", rd_busy, e); end
    e = exp_q.pop_front(); vectors++;
    if (32'(pend_cnt) !== e) begin miscompares++; $display("FAIL reset_cnt: got %h want %h", pend_cnt, e); end
    e = exp_q.pop_front(); vectors++;
    if (32'(wb_err) !== e) begin miscompares++; $display("FAIL reset_err: got %h want %h", wb_err, e); end
  endtask

  task automatic test_issue_repeat();
    iss_en = 1'b1; iss_addr = 4'd5; set_rd(5, 0, 0);
    exp_q.push_back(32'd1);
    #1;
    e = exp_q.pop_front(); vectors++;
    if (32'(iss_ok) !== e) begin miscompares++; $display("FAIL iss_r5_first: got %h want %h", iss_ok, e); end
    cyc();
    exp_q.push_back(32'd0); exp_q.push_back(32'd1); exp_q.push_back(32'd1);
    #1;
    e = exp_q.pop_front(); vectors++;
    if (32'(iss_ok) !== e) begin miscompares++; $display("FAIL iss_r5_again: got %h want %h", iss_ok, e); end
    e = exp_q.pop_front(); vectors++;
    if (32'(pend_cnt) !== e) begin miscompares++; $display("FAIL iss_cnt: got %h want %h", pend_cnt, e); end
    e = exp_q.pop_front(); vectors++;
    if (32'(rd_busy[0]) !== e) begin miscompares++; $display("FAIL iss_busy_r5: got %h want %h", rd_busy[0], e); end
    cyc(); idle();
    exp_q.push_back(32'd1);
    #1;
    e = exp_q.pop_front(); vectors++;
    if (32'(pend_cnt) !== e) begin miscompares++; $display("FAIL rejected_iss_cnt: got %h want %h", pend_cnt, e); end
  endtask

  task automatic test_wb_with_issue();
    wr_en = 1'b1; wr_addr = 4'd5; wr_data = 32'hDEADBEEF;
    iss_en = 1'b1; iss_addr = 4'd5;
    exp_q.push_back(32'd1);
    #1;
    e = exp_q.pop_front(); vectors++;
    if (32'(iss_ok) !== e) begin miscompares++; $display("FAIL wbiss_ok: got %h want %h", iss_ok, e); end
    cyc(); idle();
    exp_q.push_back(32'd1); exp_q.push_back(32'd1); exp_q.push_back(32'hDEADBEEF); exp_q.push_back(32'd0);
    #1;
    e = exp_q.pop_front(); vectors++;
    if (32'(pend_cnt) !== e) begin miscompares++; $display("FAIL wbiss_cnt: got %h want %h", pend_cnt, e); end
    e = exp_q.pop_front(); vectors++;
    if (32'(rd_busy[0]) !== e) begin miscompares++; $display("FAIL wbiss_busy: got %h want %h", rd_busy[0], e); end
    e = exp_q.pop_front(); vectors++;
    if (rd_data[31:0] !== e) begin miscompares++; $display("FAIL wbiss_data: got %h want %h", rd_data[31:0], e); end
    e = exp_q.pop_front(); vectors++;
    if (32'(wb_err) !== e) begin miscompares++; $display("FAIL wbiss_err: got %h want %h", wb_err, e); end
    wr_en = 1'b1; wr_addr = 4'd5; wr_data = 32'h11;
    cyc(); idle();
    exp_q.push_back(32'd0); exp_q.push_back(32'd0); exp_q.push_back(32'h11);
    #1;
    e = exp_q.pop_front(); vectors++;
    if (32'(pend_cnt) !== e) begin miscompares++; $display("FAIL retire_cnt: got %h want %h", pend_cnt, e); end
    e = exp_q.pop_front(); vectors++;
    if (32'(rd_busy[0]) !== e) begin miscompares++; $display("FAIL retire_busy: got %h want %h", rd_busy[0], e); end
    e = exp_q.pop_front(); vectors++;
    if (rd_data[31:0] !== e) begin miscompares++; $display("FAIL retire_data: got %h want %h", rd_data[31:0], e); end
  endtask

  task automatic test_back_to_back();
    iss_en = 1'b1; iss_addr = 4'd2;
    cyc();
    iss_addr = 4'd4; wr_en = 1'b1; wr_addr = 4'd2; wr_data = 32'h22;
    set_rd(2, 4, 0);
    cyc(); idle();
    exp_q.push_back(32'd1); exp_q.push_back(32'b010); exp_q.push_back(32'h22);
    #1;
    e = exp_q.pop_front(); vectors++;
    if (32'(pend_cnt) !== e) begin miscompares++; $display("FAIL b2b_cnt: got %h want %h", pend_cnt, e); end
    e = exp_q.pop_front(); vectors++;
    if (32'(rd_busy) !== e) begin miscompares++; $display("FAIL b2b_busy: got %h want %h", rd_busy, e); end
    e = exp_q.pop_front(); vectors++;
    if (rd_data[31:0] !== e) begin miscompares++; $display("FAIL b2b_data: got %h want %h", rd_data[31:0], e); end
    wr_en = 1'b1; wr_addr = 4'd4; wr_data = 32'h44;
    cyc(); idle();
    exp_q.push_back(32'd0); exp_q.push_back(32'd0);
    #1;
    e = exp_q.pop_front(); vectors++;
    if (32'(pend_cnt) !== e) begin miscompares++; $display("FAIL b2b_drain_cnt: got %h want %h", pend_cnt, e); end
    e = exp_q.pop_front(); vectors++;
    if (32'(wb_err) !== e) begin miscompares++; $display("FAIL b2b_err: got %h want %h", wb_err, e); end
  endtask

  task automatic test_pc();
    pc_wr = 32'h100; set_rd(0, 15, 0);
    cyc();
    exp_q.push_back(32'h100);
    e = exp_q.pop_front(); vectors++;
    if (pc_rd !== e) begin miscompares++; $display("FAIL pc_load: got %h want %h", pc_rd, e); end
    wr_en = 1'b1; wr_addr = 4'd15; wr_data = 32'h55;
    iss_en = 1'b1; iss_addr = 4'd15;
    exp_q.push_back(32'd0);
    #1;
    e = exp_q.pop_front(); vectors++;
    if (32'(iss_ok) !== e) begin miscompares++; $display("FAIL pc_iss_ok: got %h want %h", iss_ok, e); end
    cyc(); idle();
    exp_q.push_back(32'h100); exp_q.push_back(32'd0); exp_q.push_back(32'd0); exp_q.push_back(32'd0);
    #1;
    e = exp_q.pop_front(); vectors++;
    if (rd_data[63:32] !== e) begin miscompares++; $display("FAIL pc_read: got %h want %h", rd_data[63:32], e); end
    e = exp_q.pop_front(); vectors++;
    if (32'(rd_busy[1]) !== e) begin miscompares++; $display("FAIL pc_busy: got %h want %h", rd_busy[1], e); end
    e = exp_q.pop_front(); vectors++;
    if (32'(wb_err) !== e) begin miscompares++; $display("FAIL pc_wb_err: got %h want %h", wb_err, e); end
    e = exp_q.pop_front(); vectors++;
    if (32'(pend_cnt) !== e) begin miscompares++; $display("FAIL pc_cnt: got %h want %h", pend_cnt, e); end
    pc_wr = 32'h200;
    cyc();
    exp_q.push_back(32'h200);
    e = exp_q.pop_front(); vectors++;
    if (pc_rd !== e) begin miscompares++; $display("FAIL pc_reload: got %h want %h", pc_rd, e); end
  endtask

  task automatic test_wb_err();
    wr_en = 1'b1; wr_addr = 4'd3; wr_data = 32'h1234; set_rd(3, 0, 0);
    cyc(); idle();
    exp_q.push_back(32'd1); exp_q.push_back(32'h1234);
    e = exp_q.pop_front(); vectors++;
    if (32'(wb_err) !== e) begin miscompares++; $display("FAIL wberr_set: got %h want %h", wb_err, e); end
    e = exp_q.pop_front(); vectors++;
    if (rd_data[31:0] !== e) begin miscompares++; $display("FAIL wberr_data: got %h want %h", rd_data[31:0], e); end
    cyc(); cyc(); cyc();
    exp_q.push_back(32'd1);
    e = exp_q.pop_front(); vectors++;
    if (32'(wb_err) !== e) begin miscompares++; $display("FAIL wberr_sticky: got %h want %h", wb_err, e); end
  endtask

  task automatic test_bypass();
    iss_en = 1'b1; iss_addr = 4'd7;
    cyc(); idle();
    wr_en = 1'b1; wr_addr = 4'd7; wr_data = 32'hA5; set_rd(7, 0, 0);
`ifdef REGFILE_BYPASS_EN
    exp_q.push_back(32'hA5); exp_q.push_back(32'd0);
`else
    exp_q.push_back(32'd0);  exp_q.push_back(32'd1);
`endif
    #1;
    e = exp_q.pop_front(); vectors++;
    if (rd_data[31:0] !== e) begin miscompares++; $display("FAIL byp_data: got %h want %h", rd_data[31:0], e); end
    e = exp_q.pop_front(); vectors++;
    if (32'(rd_busy[0]) !== e) begin miscompares++; $display("FAIL byp_busy: got %h want %h", rd_busy[0], e); end
    cyc(); idle();
    exp_q.push_back(32'hA5); exp_q.push_back(32'd0);
    #1;
    e = exp_q.pop_front(); vectors++;
    if (rd_data[31:0] !== e) begin miscompares++; $display("FAIL byp_after: got %h want %h", rd_data[31:0], e); end
    e = exp_q.pop_front(); vectors++;
    if (32'(pend_cnt) !== e) begin miscompares++; $display("FAIL byp_cnt: got %h want %h", pend_cnt, e); end
  endtask

  task automatic test_reset_again();
    rst = 1'b1; set_rd(3, 15, 7);
    cyc();
    rst = 1'b0;
    exp_q.push_back(32'd0); exp_q.push_back(32'd0); exp_q.push_back(32'd0);
    e = exp_q.pop_front(); vectors++;
    if (32'(wb_err) !== e) begin miscompares++; $display("FAIL rst2_err: got %h want %h", wb_err, e); end
    e = exp_q.pop_front(); vectors++;
    if (rd_data[31:0] !== e) begin miscompares++; $display("FAIL rst2_r3: got %h want %h", rd_data[31:0], e); end
    e = exp_q.pop_front(); vectors++;
    if (pc_rd !== e) begin miscompares++; $display("FAIL rst2_pc: got %h want %h", pc_rd, e); end
  endtask

  initial begin
    rst = 1'b1; rd_addr = '0; pc_wr = '0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    iss_en = 1'b0; iss_addr = '0;
    test_reset();
    test_issue_repeat();
    test_wb_with_issue();
    test_back_to_back();
    test_pc();
    test_wb_err();
    test_bypass();
    test_reset_again();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 SHALL have parameter DATA_W, default 32, register data width.
REQ-002 SHALL have parameter NREGS, default 16, registers including PC; PC index = NREGS-1; AW = $clog2(NREGS).
REQ-003 SHALL have parameter NRD, default 3, number of read ports.
REQ-004 SHALL have port clk  input  1  clock, all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port rd_addr  input  NRD x AW  read addresses.
REQ-007 SHALL have port rd_data  output  NRD x DATA_W  read data.
REQ-008 SHALL have port rd_busy  output  NRD  scoreboard busy bit of each read address.
REQ-009 SHALL have port pc_wr  input  DATA_W  next PC value; pc_rd  output  DATA_W  current PC.
REQ-010 SHALL have port wr_en / wr_addr / wr_data  input  1 / AW / DATA_W  writeback port.
REQ-011 SHALL have port iss_en / iss_addr  input  1 / AW  issue request reserving a destination register.
REQ-012 SHALL have port iss_ok  output  1  issue accepted this cycle (combinational).
REQ-013 SHALL have port pend_cnt  output  AW+1  number of busy registers; wb_err  output  1  sticky error.

Function
REQ-014 SHALL return mem[rd_addr[i]] combinationally on rd_data[i]; rd_addr = NREGS-1 returns the PC.
REQ-015 SHALL load PC with pc_wr every cycle when not in reset; pc_rd = PC register.
REQ-016 SHALL write wr_data to mem[wr_addr] at the edge when wr_en=1 and wr_addr < NREGS-1; wr_addr = NREGS-1 ignored (no write, no wb_err).
REQ-017 SHALL clear busy[wr_addr] on an accepted writeback.
REQ-018 SHALL drive iss_ok=1 when iss_en=1, iss_addr < NREGS-1, and (busy[iss_addr]=0 or same-cycle writeback to iss_addr); otherwise 0.
REQ-019 SHALL set busy[iss_addr] at the edge when iss_ok=1; same-cycle writeback and issue to one register leaves busy=1 and writes data.
REQ-020 SHALL leave all state unchanged for a rejected issue (iss_ok=0).
REQ-021 SHALL set wb_err (sticky until reset) on writeback with wr_addr < NREGS-1 and busy[wr_addr]=0; data still written.
REQ-022 SHALL keep pend_cnt equal to the popcount of busy, registered, updated the same edge as busy (+1, -1, or 0 for simultaneous issue/clear).
REQ-023 SHALL drive rd_busy[i] = busy[rd_addr[i]] combinationally; 0 for PC index.

Reset
REQ-024 SHALL on rst=1 at an edge clear all registers, PC, busy, pend_cnt and wb_err to 0; wr_en/iss_en in the same cycle are ignored.
REQ-025 SHALL hold iss_ok=0 while rst=1.

Configuration
REQ-026 SHALL, with REGFILE_BYPASS_EN defined, return wr_data on rd_data[i] and 0 on rd_busy[i] when wr_en=1 and wr_addr = rd_addr[i] < NREGS-1 in the same cycle.
REQ-027 SHALL, without REGFILE_BYPASS_EN, return the stored (old) value and current busy bit in that case.

Structure
REQ-028 SHALL place PC-index helper function, AW computation and a busy-vector typedef in package regfile_pkg.
REQ-029 SHALL implement the busy vector, iss_ok, pend_cnt and wb_err in sub-module regfile_scoreboard; storage and read muxing in regfile_sb.

Verification
REQ-030 SHALL cover: reset, then read all ports addr 0..2 -> rd_data=0, rd_busy=0, pend_cnt=0, wb_err=0.
REQ-031 SHALL cover: issue R5, next cycle issue R5 again -> iss_ok 1 then 0, pend_cnt=1, rd_busy for R5 =1.
REQ-032 SHALL cover: issue R5, later wr R5=0xDEADBEEF together with issue R5 -> iss_ok=1, busy stays 1, pend_cnt=1, read R5=0xDEADBEEF next cycle.
REQ-033 SHALL cover: wr R3=0x1234 without issue -> wb_err=1 and stays 1; read R3=0x1234.
REQ-034 SHALL cover: pc_wr=0x100 then wr_addr=15 data 0x55 -> pc_rd=0x100, rd_addr=15 reads 0x100; issue to 15 gives iss_ok=0.
REQ-035 SHALL cover: wr R7=0xA5 with rd_addr[0]=7 same cycle -> rd_data[0]=0xA5 with REGFILE_BYPASS_EN, old value without.
